alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter WIDTH, default 8: ALU data width; operand and accumulator width.
REQ-002 Parameter DEPTH, default 8: program memory entries (power of two, >= 2); AW = log2(DEPTH).
REQ-003 Parameter ZF_BIT, default 0: index of the ALU zero flag within alu_flags.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_en  input  1  program write strobe; ignored while busy=1.
REQ-007 wr_addr  input  AW  program entry index.
REQ-008 wr_data  input  3+WIDTH  entry = {op[2:0], operand[WIDTH-1:0]}.
REQ-009 start  input  1  single-cycle run request; ignored while busy=1.
REQ-010 len  input  AW+1  number of entries to issue from index 0; sampled with start; values > DEPTH are clamped to DEPTH.
REQ-011 alu_control  output  3  opcode to ALU: HOLD=0, CLEAR=1, ADD=2, SUB=3, AND=4, NEG=5, NOT=6, XOR=7.
REQ-012 alu_in  output  WIDTH  operand to ALU.
REQ-013 alu_acc  input  WIDTH  ALU accumulator, registered by the ALU on the same clk.
REQ-014 alu_flags  input  4  ALU flags, registered alongside alu_acc.
REQ-015 busy  output  1  high from the cycle after accepted start until done.
REQ-016 done  output  1  one-cycle pulse at end of run.
REQ-017 result  output  WIDTH  accumulator captured at end of run.
REQ-018 result_flags  output  4  flags captured at end of run.
REQ-019 halted  output  1  set when a run ended early by zero-halt; cleared on next accepted start.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; one entry issued per cycle in ISSUE.
REQ-021 IDLE: alu_control=HOLD, alu_in=0; start with len!=0 -> ISSUE, pc=0; start with len==0 -> DONE, no issue, result unchanged.
REQ-022 ISSUE: alu_control/alu_in = program[pc] combinationally from pc; pc increments each cycle; on pc==len-1 -> WAIT.
REQ-023 WAIT: alu_control=HOLD; result<=alu_acc, result_flags<=alu_flags (ALU has updated from last issued entry) -> DONE.
REQ-024 DONE: done=1, busy=0, HOLD driven -> IDLE; start in DONE ignored.
REQ-025 Latency: accepted start to done = len+2 cycles for len>=1; 1 cycle for len==0.
REQ-026 Writes while busy=1 are dropped; write and start in the same IDLE cycle: write lands first, run sees new entry.
REQ-027 pc width AW+1; no wrap-around; len==DEPTH issues every entry exactly once.
REQ-028 alu_control is HOLD in every non-ISSUE cycle, so the accumulator is never modified outside a run.

Reset
REQ-029 rst_n low: state=IDLE, pc=0, busy=0, done=0, halted=0, result=0, result_flags=0, alu_control=HOLD, alu_in=0, immediately (asynchronous).
REQ-030 Program memory contents are not reset; reset mid-run abandons the run with no done pulse.

Configuration
REQ-031 Macro ALU_SEQ_ZERO_HALT_EN defined: in ISSUE with pc>=1, if alu_flags[ZF_BIT]==1, current cycle drives HOLD instead of program[pc], FSM -> WAIT, halted<=1.
REQ-032 Macro undefined: alu_flags ignored during ISSUE; halted tied 0; all len entries always issued.

Verification
REQ-033 Program {CLEAR,0},{ADD,5},{SUB,3}, start len=3 -> busy 1 cycle after start, done exactly 5 cycles after start, result=0x02.
REQ-034 Program {CLEAR,0},{ADD,12},{AND,9}, {XOR,0xFF}, len=4 -> result=0xF7.
REQ-035 start with len=0 after a prior run -> done 1 cycle later, result holds prior value, alu_control stays HOLD.
REQ-036 start and wr_en pulsed while busy -> no second run, program unchanged; single done pulse.
REQ-037 Program {CLEAR,0},{ADD,5},{SUB,5},{ADD,7}, len=4: with ALU_SEQ_ZERO_HALT_EN -> result=0x00, halted=1, ADD 7 never issued; without -> result=0x07, halted=0.
REQ-038 rst_n low during ISSUE -> alu_control=HOLD and busy=0 same cycle, no done; subsequent start runs normally from pc=0.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - issues a stored ALU program one entry per cycle and captures the final accumulator
// Define ALU_SEQ_ZERO_HALT_EN to end a run early once the ALU zero flag rises.
module alu_cmd_seq #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ZF_BIT = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH+2:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      len,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] alu_acc,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       result_flags,
  output logic             halted
);

  localparam logic [2:0]  OP_HOLD = 3'd0;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
`ifdef ALU_SEQ_ZERO_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH+2:0] prog [DEPTH];
  logic [WIDTH+2:0] entry;
  logic [AW:0]      pc, pc_inc, len_q, len_clamped;
  logic             halted_q, zero_hit;

  assign busy        = (state == ISSUE) || (state == WAIT);
  assign done        = (state == DONE);
  assign halted      = halted_q;
  assign pc_inc      = pc + 1'b1;
  assign len_clamped = (len > DEPTH_W) ? DEPTH_W : len;
  assign entry       = prog[pc[AW-1:0]];
  // Flags are registered by the ALU, so at pc>=1 they reflect the previously issued entry.
  assign zero_hit    = HALT_EN && (state == ISSUE) && (pc != '0) && alu_flags[ZF_BIT];

  always_ff @(posedge clk) begin
    if (wr_en && !busy) prog[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= '0;
      len_q        <= '0;
      result       <= '0;
      result_flags <= '0;
      halted_q     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          pc       <= '0;
          len_q    <= len_clamped;
          halted_q <= 1'b0;
        end
        ISSUE: begin
          pc <= pc_inc;
          if (zero_hit) halted_q <= 1'b1;
        end
        WAIT: begin
          result       <= alu_acc;
          result_flags <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    alu_control = OP_HOLD;
    alu_in      = '0;
    case (state)
      IDLE: if (start) state_n = (len_clamped == '0) ? DONE : ISSUE;
      ISSUE: begin
        if (zero_hit) begin
          state_n = WAIT;
        end else begin
          alu_control = entry[WIDTH+2:WIDTH];
          alu_in      = entry[WIDTH-1:0];
          if (pc_inc == len_q) state_n = WAIT;
        end
      end
      WAIT:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - scoreboard bench for alu_cmd_seq with a stand-in registered ALU
module tb_alu_cmd_seq;
  localparam int D = 8;
`ifdef ALU_SEQ_ZERO_HALT_EN
  localparam logic [7:0] R33 = 8'h00, R34 = 8'h00, R37 = 8'h00;
  localparam logic       H37 = 1'b1;
`else
  localparam logic [7:0] R33 = 8'h02, R34 = 8'hF7, R37 = 8'h07;
  localparam logic       H37 = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [10:0] wr_data = '0;
  logic [3:0]  len = '0;
  logic [2:0]  alu_control;
  logic [7:0]  alu_in, alu_acc, result;
  logic [3:0]  alu_flags, result_flags;
  logic        busy, done, halted;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [7:0] res; logic [3:0] fl; logic h; int cyc; } exp_t;
  exp_t        exp_q[$];
  logic [10:0] mmem [D];
  logic [7:0]  macc = '0, mres = '0;
  logic [3:0]  mfl = '0;

  alu_cmd_seq #(.WIDTH(8), .DEPTH(8), .ZF_BIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .alu_control(alu_control), .alu_in(alu_in),
    .alu_acc(alu_acc), .alu_flags(alu_flags), .busy(busy), .done(done),
    .result(result), .result_flags(result_flags), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return 8'h00;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a & b;
      3'd5:    return 8'h00 - a;
      3'd6:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input logic [7:0] a);
    return {2'b00, a[7], a == 8'h00};
  endfunction

  // Stand-in ALU: accumulator and flags registered on the same clock as the sequencer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_acc   <= 8'h00;
      alu_flags <= 4'b0001;
    end else begin
      alu_acc   <= alu_f(alu_control, alu_acc, alu_in);
      alu_flags <= flags_of(alu_f(alu_control, alu_acc, alu_in));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!busy) chk("hold_outside_run", alu_control, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("result_flags", result_flags, e.fl);
          chk("halted", halted, e.h);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wprog(input int a, input logic [10:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d;
    mmem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input int l, input bit wr0, input bit poke);
    int lc, s, issued;
    bit halt, seen;
    exp_t e;
    logic [10:0] wd;
    @(negedge clk);
    start = 1'b1; len = l[3:0]; s = cyc;
    if (wr0) begin
      wd = 11'($urandom);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = wd;
      mmem[0] = wd;
    end
    lc = (l > D) ? D : l;
    issued = 0; halt = 1'b0;
    for (int i = 0; i < lc; i++) begin
`ifdef ALU_SEQ_ZERO_HALT_EN
      if (i >= 1 && macc == 8'h00) begin halt = 1'b1; break; end
`endif
      macc = alu_f(mmem[i][10:8], macc, mmem[i][7:0]);
      issued++;
    end
    if (lc > 0) begin
      mres = macc; mfl = flags_of(macc);
      e.cyc = halt ? s + issued + 3 : s + lc + 2;
    end else begin
      e.cyc = s + 1;
    end
    e.res = mres; e.fl = mfl; e.h = halt;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (lc > 0) chk("busy_after_start", busy, 32'd1);
    else chk("done_len0", done, 32'd1);
    if (poke && lc > 0) begin
      start = 1'b1; len = 4'd3;
      wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 3)); wr_data = 11'($urandom);
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done at cycle %0d", e.cyc);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_halted", halted, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_result_flags", result_flags, 32'd0);
    chk("rst_alu_control", alu_control, 32'd0);
    chk("rst_alu_in", alu_in, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++) wprog(i, 11'($urandom));

    wprog(0, {3'd1, 8'd0}); wprog(1, {3'd2, 8'd5}); wprog(2, {3'd3, 8'd3});
    run(3, 1'b0, 1'b0);
    chk("prog_a_result", result, R33);

    wprog(0, {3'd1, 8'd0}); wprog(1, {3'd2, 8'd12}); wprog(2, {3'd4, 8'd9}); wprog(3, {3'd7, 8'hFF});
    run(4, 1'b0, 1'b0);
    chk("prog_b_result", result, R34);

    run(0, 1'b0, 1'b0);
    chk("len0_holds_result", result, R34);

    run(4, 1'b0, 1'b1);
    run(4, 1'b0, 1'b0);
    chk("prog_unchanged_after_busy_write", result, R34);

    wprog(0, {3'd1, 8'd0}); wprog(1, {3'd2, 8'd5}); wprog(2, {3'd3, 8'd5}); wprog(3, {3'd2, 8'd7});
    run(4, 1'b0, 1'b0);
    chk("zero_prog_result", result, R37);
    chk("zero_prog_halted", halted, H37);

    run(15, 1'b0, 1'b0);
    run(8, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0);

    @(negedge clk);
    start = 1'b1; len = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_alu_control", alu_control, 32'd0);
    chk("midrun_rst_busy", busy, 32'd0);
    chk("midrun_rst_done", done, 32'd0);
    chk("midrun_rst_result", result, 32'd0);
    macc = 8'h00; mres = 8'h00; mfl = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) wprog($urandom_range(0, D - 1), 11'($urandom));
      run($urandom_range(0, 15), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
